// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the UART debug loader.
// Command bytes arrive from the host; reply bytes go back through the UART transmitter.
package debug_pkg;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_SEND,
        ST_ACK,
        ST_NAK
    } dbg_state_t;

endpackage

// File: rtl/debug_loader_ctrl.sv
// Byte-stream command sequencer driving the shared memory debug bus.
// It assembles little-endian address and data words and returns ACK/NAK or read data.
module debug_loader_ctrl
    import debug_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        clk_cpu,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] debug_addr,
    output logic        debug_we,
    inout  wire  [31:0] debug_data,
    output logic        cpu_halt
);

    localparam int CW = $clog2(TIMEOUT + 1);

    dbg_state_t    state;
    logic [1:0]    byte_cnt;
    logic          is_write;
    logic          frame_done;
    logic [CW-1:0] idle_cnt;
    logic [31:0]   addr_sr;
    logic [31:0]   data_sr;
    logic [31:0]   rd_sr;

    // Transmit handshake: a byte moves when tx_valid && tx_ready at posedge;
    // tx_valid/tx_data stay put until then.
    logic tx_fire;
    assign tx_fire = tx_valid && tx_ready;

    assign debug_data = debug_we ? data_sr : 32'bz;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            byte_cnt   <= 2'd0;
            is_write   <= 1'b0;
            frame_done <= 1'b0;
            idle_cnt   <= '0;
            addr_sr    <= 32'd0;
            data_sr    <= 32'd0;
            rd_sr      <= 32'd0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            debug_addr <= 32'd0;
            debug_we   <= 1'b0;
            cpu_halt   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        byte_cnt   <= 2'd0;
                        idle_cnt   <= '0;
                        frame_done <= 1'b0;
                        case (rx_data)
                            CMD_WR, CMD_RD: begin
                                is_write <= (rx_data == CMD_WR);
                                state    <= ST_GET_ADDR;
                            end
                            CMD_HALT: begin
                                cpu_halt <= 1'b1;
                                tx_valid <= 1'b1;
                                tx_data  <= RSP_ACK;
                                state    <= ST_ACK;
                            end
                            CMD_GO: begin
                                cpu_halt <= 1'b0;
                                tx_valid <= 1'b1;
                                tx_data  <= RSP_ACK;
                                state    <= ST_ACK;
                            end
                            default: begin
                                tx_valid <= 1'b1;
                                tx_data  <= RSP_NAK;
                                state    <= ST_NAK;
                            end
                        endcase
                    end
                end

                ST_GET_ADDR, ST_GET_DATA: begin
                    // The final byte of a frame is followed by one settling cycle
                    // before the memory state; bytes arriving then are dropped.
                    if (frame_done) begin
                        frame_done <= 1'b0;
                        debug_addr <= addr_sr;
                        if (state == ST_GET_DATA) begin
                            debug_we <= 1'b1;
                            state    <= ST_MEM_WR;
                        end else begin
                            state    <= ST_MEM_RD;
                        end
                    end else if (rx_valid) begin
                        idle_cnt <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (state == ST_GET_ADDR)
                            addr_sr <= {rx_data, addr_sr[31:8]};
                        else
                            data_sr <= {rx_data, data_sr[31:8]};
                        if (byte_cnt == 2'd3) begin
                            if (state == ST_GET_ADDR && is_write)
                                state <= ST_GET_DATA;
                            else
                                frame_done <= 1'b1;
                        end
                    end else if (idle_cnt == CW'(TIMEOUT - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end

                ST_MEM_WR: begin
                    if (clk_cpu) begin
                        debug_we <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_data  <= RSP_ACK;
                        state    <= ST_ACK;
                    end
                end

                ST_MEM_RD: begin
                    if (clk_cpu) begin
                        rd_sr    <= debug_data;
                        tx_valid <= 1'b1;
                        tx_data  <= debug_data[7:0];
                        byte_cnt <= 2'd0;
                        state    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (tx_fire) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            tx_valid <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            tx_data <= rd_sr[15:8];
                            rd_sr   <= {8'h00, rd_sr[31:8]};
                        end
                    end
                end

                ST_ACK, ST_NAK: begin
                    if (tx_fire) begin
                        tx_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_loader_ctrl.sv
// Bench for debug_loader_ctrl: directed scenarios plus random command streams,
// scored against a command-level model of memory, halt flag and reply bytes.
module tb_debug_loader_ctrl;
    import debug_pkg::*;

    localparam int TMO = 40;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        clk_cpu = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [31:0] debug_addr;
    logic        debug_we;
    wire  [31:0] debug_data;
    logic        cpu_halt;

    // Memory environment: read data appears on the bus whenever nobody writes
    logic [31:0] env_mem [0:8191];
    logic [31:0] rd_word;
    assign rd_word    = env_mem[debug_addr[14:2]];
    assign debug_data = debug_we ? 32'bz : rd_word;

    debug_loader_ctrl #(.TIMEOUT(TMO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .clk_cpu    (clk_cpu),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .debug_addr (debug_addr),
        .debug_we   (debug_we),
        .debug_data (debug_data),
        .cpu_halt   (cpu_halt)
    );

    always #5 CLK = ~CLK;

    // Reference model state
    logic [31:0] model_mem [int];
    logic        model_halt = 1'b0;
    logic [7:0]  exp_q [$];
    logic [63:0] exp_wr_q [$];
    bit          rand_cpu = 1'b0;
    bit          rand_ready = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_cpu)   clk_cpu  = ($urandom_range(0, 2) != 0);
        if (rand_ready) tx_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Scoreboard: every tx handshake and every effective memory write is matched in order
    task automatic monitor();
        forever begin
            @(negedge CLK);
            if (!RST && tx_valid && tx_ready) begin
                if (exp_q.size() == 0)
                    check("tx_unexpected", 64'(exp_q.size()), 64'd1);
                else
                    check("tx_byte", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
            end
            if (!RST && debug_we && clk_cpu) begin
                env_mem[debug_addr[14:2]] = debug_data;
                if (exp_wr_q.size() == 0)
                    check("wr_unexpected", 64'(exp_wr_q.size()), 64'd1);
                else
                    check("wr_word", {debug_addr, debug_data}, exp_wr_q.pop_front());
            end
        end
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input int gap);
        logic [31:0] w;
        int          key;
        key = int'(addr[14:2]);
        case (op)
            CMD_WR: begin
                model_mem[key] = data;
                exp_wr_q.push_back({addr, data});
                exp_q.push_back(RSP_ACK);
            end
            CMD_RD: begin
                w = model_mem.exists(key) ? model_mem[key] : 32'd0;
                for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
            end
            CMD_HALT: begin
                model_halt = 1'b1;
                exp_q.push_back(RSP_ACK);
            end
            CMD_GO: begin
                model_halt = 1'b0;
                exp_q.push_back(RSP_ACK);
            end
            default: exp_q.push_back(RSP_NAK);
        endcase
        send_byte(op);
        if (op == CMD_WR || op == CMD_RD) begin
            for (int i = 0; i < 4; i++) begin
                repeat (gap) tick();
                send_byte(addr[8*i +: 8]);
            end
        end
        if (op == CMD_WR) begin
            for (int i = 0; i < 4; i++) begin
                repeat (gap) tick();
                send_byte(data[8*i +: 8]);
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while ((exp_q.size() != 0 || exp_wr_q.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        check("resp_done", 64'(exp_q.size() + exp_wr_q.size()), 64'd0);
        exp_q.delete();
        exp_wr_q.delete();
        tick();
        check("cpu_halt", {63'd0, cpu_halt}, {63'd0, model_halt});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  op;
        logic [31:0] addr;
        int          r;
        for (int i = 0; i < 8192; i++) env_mem[i] = 32'd0;
        fork
            monitor();
        join_none

        // Reset values
        repeat (3) tick();
        @(negedge CLK);
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_data", {56'd0, tx_data}, 64'd0);
        check("rst_addr", {32'd0, debug_addr}, 64'd0);
        check("rst_we", {63'd0, debug_we}, 64'd0);
        check("rst_halt", {63'd0, cpu_halt}, 64'd0);
        tick();
        RST = 1'b0;
        tick();

        // Back-to-back write with clk_cpu high: one-cycle strobe, ACK two cycles after last byte
        run_cmd(CMD_WR, 32'h0000_4000, 32'hDEAD_BEEF, 0);
        @(negedge CLK);
        check("wr_we_early", {63'd0, debug_we}, 64'd0);
        @(negedge CLK);
        check("wr_we", {63'd0, debug_we}, 64'd1);
        check("wr_addr", {32'd0, debug_addr}, 64'h4000);
        check("wr_data", {32'd0, debug_data}, 64'hDEAD_BEEF);
        check("wr_tx_early", {63'd0, tx_valid}, 64'd0);
        @(negedge CLK);
        check("ack_valid", {63'd0, tx_valid}, 64'd1);
        check("ack_data", {56'd0, tx_data}, 64'h06);
        check("wr_we_once", {63'd0, debug_we}, 64'd0);
        wait_done();

        // Read back, halt, go, unknown command
        run_cmd(CMD_RD, 32'h0000_4000, 32'd0, 1);
        wait_done();
        run_cmd(CMD_HALT, 32'd0, 32'd0, 0);
        wait_done();
        run_cmd(CMD_GO, 32'd0, 32'd0, 0);
        wait_done();
        run_cmd(8'h99, 32'd0, 32'd0, 0);
        wait_done();

        // Enable stall: strobe held while clk_cpu is low
        clk_cpu = 1'b0;
        run_cmd(CMD_WR, 32'h0000_4008, $urandom, 0);
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("stall_we", {63'd0, debug_we}, 64'd1);
            check("stall_tx", {63'd0, tx_valid}, 64'd0);
        end
        check("stall_no_wr", 64'(exp_wr_q.size()), 64'd1);
        @(posedge CLK);
        #1;
        clk_cpu = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("stall_ack", {63'd0, tx_valid}, 64'd1);
        wait_done();

        // Slow but legal byte spacing must not trip the idle timeout
        run_cmd(CMD_RD, 32'h0000_4008, 32'd0, TMO - 5);
        wait_done();

        // Abandoned write times out silently; the next byte is a fresh command
        send_byte(CMD_WR);
        send_byte(8'h00);
        send_byte(8'h40);
        repeat (TMO + 5) tick();
        check("tmo_no_tx", {63'd0, tx_valid}, 64'd0);
        run_cmd(CMD_HALT, 32'd0, 32'd0, 0);
        wait_done();
        run_cmd(CMD_GO, 32'd0, 32'd0, 0);
        wait_done();

        // Transmit backpressure holds the first reply byte
        tx_ready = 1'b0;
        run_cmd(CMD_RD, 32'h0000_4000, 32'd0, 0);
        r = 0;
        while (!tx_valid && r < 50) begin
            tick();
            r++;
        end
        check("bp_valid", {63'd0, tx_valid}, 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("bp_hold", {56'd0, tx_data}, {56'd0, exp_q[0]});
        end
        tick();
        tx_ready = 1'b1;
        wait_done();

        // Reset during data collection aborts the write and clears the halt flag
        run_cmd(CMD_HALT, 32'd0, 32'd0, 0);
        wait_done();
        send_byte(CMD_WR);
        send_byte(8'h10);
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        RST = 1'b1;
        tick();
        @(negedge CLK);
        check("mrst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("mrst_tx_data", {56'd0, tx_data}, 64'd0);
        check("mrst_addr", {32'd0, debug_addr}, 64'd0);
        check("mrst_we", {63'd0, debug_we}, 64'd0);
        check("mrst_halt", {63'd0, cpu_halt}, 64'd0);
        model_halt = 1'b0;
        tick();
        RST = 1'b0;
        tick();
        run_cmd(CMD_RD, 32'h0000_4010, 32'd0, 0);
        wait_done();

        // Random command stream with random enable and transmitter readiness
        rand_cpu   = 1'b1;
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r    = $urandom_range(0, 9);
            addr = $urandom;
            addr[14:2] = 13'($urandom_range(0, 7));
            if (r < 4)       op = CMD_WR;
            else if (r < 7)  op = CMD_RD;
            else if (r == 7) op = CMD_HALT;
            else if (r == 8) op = CMD_GO;
            else begin
                op = 8'($urandom);
                while (op == CMD_WR || op == CMD_RD || op == CMD_HALT || op == CMD_GO)
                    op = 8'($urandom);
            end
            run_cmd(op, addr, $urandom, $urandom_range(0, 3));
            wait_done();
        end
        rand_cpu   = 1'b0;
        rand_ready = 1'b0;
        clk_cpu    = 1'b1;
        tx_ready   = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/debug_loader_ctrl.md
# debug_loader_ctrl

Command sequencer for the debug port of the instruction and data memories. It parses a byte stream from the UART receiver, assembles 32-bit addresses and data words, and drives the shared `debug_addr` / `debug_we` / `debug_data` bus for word writes and reads. It returns acknowledgements and read data to the UART transmitter, and exposes a CPU halt flag so the host can load a program while the core is stopped.

## Interface
- `TIMEOUT`, default 1_000_000: maximum number of CLK cycles allowed between bytes of one command before the command is aborted.
- `CLK  in  1`: system clock; all logic is on posedge.
- `RST  in  1`: reset, synchronous and active-high.
- `clk_cpu  in  1`: CLK-synchronous enable strobe. The memories act only on a CLK negedge while this is high.
- `rx_valid  in  1`: single-cycle pulse; a received byte is present.
- `rx_data  in  8`: received byte.
- `tx_valid  out  1`: byte offered to the UART transmitter.
- `tx_data  out  8`: byte to transmit.
- `tx_ready  in  1`: transmitter accepts a byte when `tx_valid && tx_ready` at posedge.
- `debug_addr  out  32`: byte address to the memories (word index is `[13:2]`; bit 14 selects the memory).
- `debug_we  out  1`: write strobe.
- `debug_data  inout  32`: driven with the write word only while `debug_we`=1, Z otherwise.
- `cpu_halt  out  1`: the core stalls while this is 1.

## Operation
- Command bytes:
  - `0x57` 'W': followed by 4 address bytes, then 4 data bytes, both little-endian. Writes the word, then replies `0x06`.
  - `0x52` 'R': followed by 4 address bytes. Replies with 4 data bytes, LSB first.
  - `0x48` 'H': sets `cpu_halt`, replies `0x06`.
  - `0x47` 'G': clears `cpu_halt`, replies `0x06`.
  - Any other value: replies `0x15` and discards the byte.
- States and transitions:
  - IDLE: on an accepted byte, decode it and go to GET_ADDR, ACK or NAK.
  - GET_ADDR: collect 4 bytes with a 2-bit byte counter. Then go to GET_DATA for W, or MEM_RD for R.
  - GET_DATA: collect 4 bytes, then go to MEM_WR.
  - MEM_WR: hold address, data and `debug_we`=1 until a posedge with `clk_cpu`=1, then go to ACK.
  - MEM_RD: hold the address with `debug_we`=0 until a posedge with `clk_cpu`=1. Capture `debug_data` into the reply register on that edge, then go to SEND.
  - SEND: shift out 4 bytes, LSB first, one per accepted tx handshake, then go to IDLE.
  - ACK / NAK: offer one byte, then go to IDLE.
- Receive rules:
  - `rx_valid` pulses that arrive outside IDLE, GET_ADDR and GET_DATA are dropped; no buffering.
  - The idle counter resets on every accepted byte and runs only in GET_ADDR and GET_DATA. When it reaches `TIMEOUT`-1, return to IDLE silently, with no reply and no memory access.
- Output rules:
  - `debug_addr` is held at its last value outside the memory states.
  - `debug_we` is 1 only in MEM_WR. The write is always a full word; there are no byte enables on this port.
  - `cpu_halt` is not changed by W or R commands.

## Timing
- Reset values:
  - State: IDLE.
  - `tx_valid`=0, `tx_data`=0x00.
  - `debug_addr`=0, `debug_we`=0, `debug_data`=Z.
  - `cpu_halt`=0.
  - Counters: 0.
- The last byte of a command is accepted at posedge k; the FSM enters its next state at posedge k+1.
- A memory access completes at the first posedge with `clk_cpu`=1 after the state is entered, i.e. at least 1 cycle.
- Write-acknowledge latency:
  - With `clk_cpu` held at 1: `tx_valid` rises 2 cycles after the last data byte.
  - With `clk_cpu`=0: latency stretches until `clk_cpu` rises.
- `tx_valid`/`tx_data` stay stable until `tx_ready`; there is no timeout while waiting on the transmitter.
- `rx_valid` in the same cycle as a state exit is ignored.
- RST mid-operation aborts any command. `cpu_halt` returns to 0.

## Structure
- `debug_pkg` holds:
  - Command and reply constants: `CMD_WR`, `CMD_RD`, `CMD_HALT`, `CMD_GO`, `RSP_ACK`, `RSP_NAK`.
  - The state enum `dbg_state_t`.
- Single module, no sub-modules. The tristate on `debug_data` is a continuous assignment in this module.

## Test plan
- Write: send `57 00 40 00 00 EF BE AD DE` with `clk_cpu`=1. Expect `debug_addr`=0x00004000, `debug_data`=0xDEADBEEF, `debug_we`=1 for exactly one cycle, then tx `0x06`.
- Read back: after the write, send `52 00 40 00 00`. Expect tx `EF BE AD DE` in order, with `debug_we`=0 throughout.
- Halt/go: send `48` → `cpu_halt`=1 and tx `06`. Then send `47` → `cpu_halt`=0 and tx `06`. Then send `99` → tx `15`, `cpu_halt` unchanged.
- Enable stall: during a W command, hold `clk_cpu`=0 for 5 cycles after the last byte. Expect `debug_we` held high for all 5 cycles, the write completing on the first `clk_cpu`=1 edge, then the ACK.
- Timeout and backpressure:
  - Send `57 00 40` then idle for `TIMEOUT` cycles. Expect a return to IDLE, no reply and no write; a following `48` is decoded as HALT.
  - Hold `tx_ready`=0 during a read reply. Expect `tx_data` held stable.
- Reset mid-command: assert RST during GET_DATA. Expect all outputs at their reset values next cycle and no write performed.
